// File: rtl/axicb_mst_switch_gen.sv
// axicb_mst_switch_gen: N-master to 1-slave AXI switch with RR AW/AR arbitration, W grant FIFO and ID-mask B/R routing
module axicb_mst_switch_gen #(
  parameter int AXI_ID_W = 8,
  parameter int MST_NB = 4,
  parameter logic [MST_NB*AXI_ID_W-1:0] MST_ID_MASK = {8'h30, 8'h20, 8'h10, 8'h00},
  parameter int AWCH_W = 8,
  parameter int WCH_W = 8,
  parameter int BCH_W = 8,
  parameter int ARCH_W = 8,
  parameter int RCH_W = 8,
  parameter int WGNT_DEPTH = 8,
  parameter int MAX_OSTDG = 4,
  localparam int OW = $clog2(MAX_OSTDG + 1)
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [MST_NB-1:0]          i_awvalid,
  output logic [MST_NB-1:0]          i_awready,
  input  logic [MST_NB*AWCH_W-1:0]   i_awch,
  input  logic [MST_NB-1:0]          i_wvalid,
  output logic [MST_NB-1:0]          i_wready,
  input  logic [MST_NB-1:0]          i_wlast,
  input  logic [MST_NB*WCH_W-1:0]    i_wch,
  output logic [MST_NB-1:0]          i_bvalid,
  input  logic [MST_NB-1:0]          i_bready,
  output logic [BCH_W-1:0]           i_bch,
  input  logic [MST_NB-1:0]          i_arvalid,
  output logic [MST_NB-1:0]          i_arready,
  input  logic [MST_NB*ARCH_W-1:0]   i_arch,
  output logic [MST_NB-1:0]          i_rvalid,
  input  logic [MST_NB-1:0]          i_rready,
  output logic [MST_NB-1:0]          i_rlast,
  output logic [RCH_W-1:0]           i_rch,
  output logic                       o_awvalid,
  input  logic                       o_awready,
  output logic [AWCH_W-1:0]          o_awch,
  output logic                       o_wvalid,
  input  logic                       o_wready,
  output logic                       o_wlast,
  output logic [WCH_W-1:0]           o_wch,
  input  logic                       o_bvalid,
  output logic                       o_bready,
  input  logic [BCH_W-1:0]           o_bch,
  output logic                       o_arvalid,
  input  logic                       o_arready,
  output logic [ARCH_W-1:0]          o_arch,
  input  logic                       o_rvalid,
  output logic                       o_rready,
  input  logic                       o_rlast,
  input  logic [RCH_W-1:0]           o_rch,
  output logic [OW-1:0]              wr_ostdg,
  output logic [OW-1:0]              rd_ostdg,
  output logic                       err_unrouted
);
  localparam int IW = $clog2(MST_NB);
  localparam int DW = $clog2(WGNT_DEPTH);

  // Returns {hit, index} of the first requester at or after p, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [MST_NB-1:0] req, input logic [IW-1:0] p);
    logic [2*MST_NB-1:0] dbl;
    logic [IW:0] s;
    rr_pick = '0;
    dbl = {req, req} >> p;
    for (int k = MST_NB - 1; k >= 0; k--) begin
      s = {1'b0, p} + (IW+1)'(k);
      s = (s >= (IW+1)'(MST_NB)) ? s - (IW+1)'(MST_NB) : s;
      if (dbl[k]) rr_pick = {1'b1, s[IW-1:0]};
    end
  endfunction

  // Lowest-index master whose mask bits are all set in the ID wins.
  function automatic logic [IW:0] route(input logic [AXI_ID_W-1:0] id);
    logic [AXI_ID_W-1:0] m;
    route = '0;
    for (int i = MST_NB - 1; i >= 0; i--) begin
      m = MST_ID_MASK[i*AXI_ID_W +: AXI_ID_W];
      if ((id & m) == m) route = {1'b1, IW'(i)};
    end
  endfunction

  function automatic logic [IW-1:0] inc_ptr(input logic [IW-1:0] p);
    return (p == IW'(MST_NB - 1)) ? '0 : p + IW'(1);
  endfunction

  logic en;
  logic [IW-1:0] aw_ptr_q, aw_ptr_d, ar_ptr_q, ar_ptr_d;
  logic [IW-1:0] aw_lidx_q, aw_lidx_d, ar_lidx_q, ar_lidx_d;
  logic aw_lock_q, aw_lock_d, ar_lock_q, ar_lock_d;
  logic [DW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DW:0] cnt_q, cnt_d;
  logic [IW-1:0] mem_q [WGNT_DEPTH];
  logic [OW-1:0] wr_ostdg_q, wr_ostdg_d, rd_ostdg_q, rd_ostdg_d;
  logic err_q, err_d;
  logic [IW:0] aw_pick, ar_pick, b_tgt, r_tgt;
  logic [IW-1:0] hd;
  logic aw_ok, ar_ok, ne, aw_hs, ar_hs, w_pop, b_hs, r_hs;

  always_comb begin
    en = ~areset;
    aw_pick = aw_lock_q ? {1'b1, aw_lidx_q} : rr_pick(i_awvalid, aw_ptr_q);
    ar_pick = ar_lock_q ? {1'b1, ar_lidx_q} : rr_pick(i_arvalid, ar_ptr_q);
    aw_ok = (cnt_q != (DW+1)'(WGNT_DEPTH)) && (wr_ostdg_q < OW'(MAX_OSTDG));
    ar_ok = rd_ostdg_q < OW'(MAX_OSTDG);
    o_awvalid = en & aw_pick[IW] & i_awvalid[aw_pick[IW-1:0]] & aw_ok;
    i_awready = (en & aw_pick[IW] & o_awready & aw_ok) ? MST_NB'(1) << aw_pick[IW-1:0] : '0;
    o_awch = aw_pick[IW] ? i_awch[aw_pick[IW-1:0]*AWCH_W +: AWCH_W] : '0;
    o_arvalid = en & ar_pick[IW] & i_arvalid[ar_pick[IW-1:0]] & ar_ok;
    i_arready = (en & ar_pick[IW] & o_arready & ar_ok) ? MST_NB'(1) << ar_pick[IW-1:0] : '0;
    o_arch = ar_pick[IW] ? i_arch[ar_pick[IW-1:0]*ARCH_W +: ARCH_W] : '0;
    aw_hs = o_awvalid & o_awready;
    ar_hs = o_arvalid & o_arready;
    ne = cnt_q != '0;
    hd = mem_q[rp_q];
    o_wvalid = en & ne & i_wvalid[hd];
    o_wlast = ne & i_wlast[hd];
    o_wch = ne ? i_wch[hd*WCH_W +: WCH_W] : '0;
    i_wready = (en & ne & o_wready) ? MST_NB'(1) << hd : '0;
    w_pop = o_wvalid & o_wready & o_wlast;
    b_tgt = route(o_bch[AXI_ID_W-1:0]);
    r_tgt = route(o_rch[AXI_ID_W-1:0]);
    i_bvalid = (en & b_tgt[IW] & o_bvalid) ? MST_NB'(1) << b_tgt[IW-1:0] : '0;
    o_bready = en & (b_tgt[IW] ? i_bready[b_tgt[IW-1:0]] : 1'b1);
    i_bch = o_bch;
    i_rvalid = (en & r_tgt[IW] & o_rvalid) ? MST_NB'(1) << r_tgt[IW-1:0] : '0;
    i_rlast = (r_tgt[IW] & o_rlast) ? MST_NB'(1) << r_tgt[IW-1:0] : '0;
    o_rready = en & (r_tgt[IW] ? i_rready[r_tgt[IW-1:0]] : 1'b1);
    i_rch = o_rch;
    b_hs = o_bvalid & o_bready;
    r_hs = o_rvalid & o_rready & o_rlast;
  end

  always_comb begin
    aw_ptr_d = aw_hs ? inc_ptr(aw_pick[IW-1:0]) : aw_ptr_q;
    ar_ptr_d = ar_hs ? inc_ptr(ar_pick[IW-1:0]) : ar_ptr_q;
    aw_lock_d = o_awvalid & ~o_awready;
    ar_lock_d = o_arvalid & ~o_arready;
    aw_lidx_d = aw_pick[IW-1:0];
    ar_lidx_d = ar_pick[IW-1:0];
    wp_d = aw_hs ? wp_q + DW'(1) : wp_q;
    rp_d = w_pop ? rp_q + DW'(1) : rp_q;
    cnt_d = (aw_hs & ~w_pop) ? cnt_q + (DW+1)'(1) : (w_pop & ~aw_hs) ? cnt_q - (DW+1)'(1) : cnt_q;
    wr_ostdg_d = (aw_hs & ~b_hs) ? wr_ostdg_q + OW'(1) :
                 (b_hs & ~aw_hs & wr_ostdg_q != '0) ? wr_ostdg_q - OW'(1) : wr_ostdg_q;
    rd_ostdg_d = (ar_hs & ~r_hs) ? rd_ostdg_q + OW'(1) :
                 (r_hs & ~ar_hs & rd_ostdg_q != '0) ? rd_ostdg_q - OW'(1) : rd_ostdg_q;
    err_d = err_q | (o_bvalid & ~b_tgt[IW]) | (o_rvalid & ~r_tgt[IW]);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_ptr_q <= '0;
      ar_ptr_q <= '0;
      aw_lock_q <= 1'b0;
      ar_lock_q <= 1'b0;
      aw_lidx_q <= '0;
      ar_lidx_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      wr_ostdg_q <= '0;
      rd_ostdg_q <= '0;
      err_q <= 1'b0;
    end else begin
      aw_ptr_q <= aw_ptr_d;
      ar_ptr_q <= ar_ptr_d;
      aw_lock_q <= aw_lock_d;
      ar_lock_q <= ar_lock_d;
      aw_lidx_q <= aw_lidx_d;
      ar_lidx_q <= ar_lidx_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      wr_ostdg_q <= wr_ostdg_d;
      rd_ostdg_q <= rd_ostdg_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (aw_hs) mem_q[wp_q] <= aw_pick[IW-1:0];
  end

  assign wr_ostdg = wr_ostdg_q;
  assign rd_ostdg = rd_ostdg_q;
  assign err_unrouted = err_q;
endmodule

// File: tb/tb_axicb_mst_switch_gen.sv
// tb_axicb_mst_switch_gen: directed checks of arbitration, W ordering, routing, outstanding limits and reset.
module tb_axicb_mst_switch_gen;
  logic aclk = 1'b0, areset = 1'b1;
  logic [3:0] i_awvalid, i_awready, i_wvalid, i_wready, i_wlast, i_bvalid, i_bready;
  logic [3:0] i_arvalid, i_arready, i_rvalid, i_rready, i_rlast;
  logic [31:0] i_awch, i_wch, i_arch;
  logic [7:0] i_bch, i_rch, o_awch, o_wch, o_bch, o_arch, o_rch;
  logic o_awvalid, o_awready, o_wvalid, o_wready, o_wlast, o_bvalid, o_bready;
  logic o_arvalid, o_arready, o_rvalid, o_rready, o_rlast, err_unrouted;
  logic [2:0] wr_ostdg, rd_ostdg;
  int n_chk = 0, n_err = 0;
  int wexp [5] = '{0, 1, 2, 3, 2};

  always #5 aclk = ~aclk;

  // Mask 01 for master 0 so an unroutable ID exists.
  axicb_mst_switch_gen #(.MST_ID_MASK({8'h30, 8'h20, 8'h10, 8'h01})) dut (
    .aclk(aclk), .areset(areset),
    .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
    .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
    .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
    .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
    .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
    .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
    .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
    .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch),
    .wr_ostdg(wr_ostdg), .rd_ostdg(rd_ostdg), .err_unrouted(err_unrouted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge aclk);
    #2;
  endtask

  task automatic idle;
    {i_awvalid, i_wvalid, i_wlast, i_bready, i_arvalid, i_rready} = '0;
    {o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast} = '0;
    o_bch = '0;
    o_rch = '0;
  endtask

  initial begin
    idle();
    i_awch = 32'hA3A2A1A0;
    i_wch = 32'hB3B2B1B0;
    i_arch = 32'hC3C2C1C0;
    repeat (3) @(posedge aclk);
    #2;
    chk("rst_bready", o_bready, 0);
    chk("rst_rready", o_rready, 0);
    chk("rst_wr", wr_ostdg, 0);
    chk("rst_rd", rd_ostdg, 0);
    chk("rst_err", err_unrouted, 0);
    areset = 1'b0;
    // All four masters request: grants rotate 0..3.
    i_awvalid = 4'hF;
    o_awready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_awready", i_awready, 32'(1 << k));
      chk("rr_awch", o_awch, 32'hA0 + 32'(k));
      cyc();
    end
    i_awvalid = 4'b0100;
    #1;
    chk("lim_awvalid", o_awvalid, 0);
    chk("lim_wr", wr_ostdg, 4);
    o_bvalid = 1'b1;
    o_bch = 8'h24;
    i_bready = 4'hF;
    #1;
    chk("b24_bvalid", i_bvalid, 4'b0100);
    chk("b24_bready", o_bready, 1);
    cyc();
    o_bvalid = 1'b0;
    #1;
    chk("lim2_awvalid", o_awvalid, 1);
    chk("lim2_awready", i_awready, 4'b0100);
    chk("lim2_awch", o_awch, 32'hA2);
    chk("lim2_wr", wr_ostdg, 3);
    cyc();
    i_awvalid = '0;
    #1;
    chk("lim3_wr", wr_ostdg, 4);
    // W drains in AW grant order 0,1,2,3,2.
    i_wvalid = 4'hF;
    i_wlast = 4'hF;
    o_wready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("word_wready", i_wready, 32'(1 << wexp[k]));
      chk("word_wch", o_wch, 32'hB0 + 32'(wexp[k]));
      cyc();
    end
    #1;
    chk("wempty_wvalid", o_wvalid, 0);
    i_wvalid = '0;
    o_bvalid = 1'b1;
    o_bch = 8'h01;
    #1;
    chk("b01_bvalid", i_bvalid, 4'b0001);
    repeat (5) cyc();
    o_bvalid = 1'b0;
    #1;
    chk("bdrain_wr", wr_ostdg, 0);
    // Master 1 burst while master 3 W is valid throughout.
    i_wvalid = 4'b1010;
    i_wlast = 4'b1000;
    i_awvalid = 4'b0010;
    #1;
    chk("m1_awready", i_awready, 4'b0010);
    chk("nobypass_wready", i_wready, 0);
    chk("nobypass_wvalid", o_wvalid, 0);
    cyc();
    i_awvalid = '0;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) i_wlast = 4'b1010;
      #1;
      chk("m1_wready", i_wready, 4'b0010);
      chk("m1_wch", o_wch, 32'hB1);
      chk("m1_wlast", o_wlast, (b == 3) ? 1 : 0);
      cyc();
    end
    #1;
    chk("m1done_wready", i_wready, 0);
    i_awvalid = 4'b1000;
    #1;
    chk("m3_awready", i_awready, 4'b1000);
    cyc();
    i_awvalid = '0;
    #1;
    chk("m3_wready", i_wready, 4'b1000);
    chk("m3_wch", o_wch, 32'hB3);
    cyc();
    i_wvalid = '0;
    // Lock: master 2 stalled, master 0 joins but must wait.
    i_awvalid = 4'b0100;
    o_awready = 1'b0;
    #1;
    chk("lk_awvalid", o_awvalid, 1);
    chk("lk_awready", i_awready, 0);
    chk("lk_awch0", o_awch, 32'hA2);
    cyc();
    i_awvalid = 4'b0101;
    repeat (2) begin
      #1;
      chk("lk_awch", o_awch, 32'hA2);
      cyc();
    end
    o_awready = 1'b1;
    #1;
    chk("lk_rel", i_awready, 4'b0100);
    cyc();
    i_awvalid = 4'b0001;
    #1;
    chk("lk_next", i_awready, 4'b0001);
    cyc();
    i_awvalid = '0;
    #1;
    chk("lk_wr", wr_ostdg, 4);
    // AR arbitration and R routing.
    i_arvalid = 4'b0110;
    o_arready = 1'b1;
    #1;
    chk("ar1_ready", i_arready, 4'b0010);
    chk("ar1_ch", o_arch, 32'hC1);
    cyc();
    #1;
    chk("ar2_ready", i_arready, 4'b0100);
    cyc();
    i_arvalid = '0;
    #1;
    chk("ar_rd", rd_ostdg, 2);
    o_rvalid = 1'b1;
    o_rch = 8'h34;
    i_rready = 4'hF;
    #1;
    chk("r34_rvalid", i_rvalid, 4'b0010);
    chk("r34_rlast", i_rlast, 0);
    chk("r34_rready", o_rready, 1);
    cyc();
    o_rlast = 1'b1;
    #1;
    chk("rnolast_rd", rd_ostdg, 2);
    chk("r34_rlast1", i_rlast, 4'b0010);
    cyc();
    o_rvalid = 1'b0;
    o_rlast = 1'b0;
    #1;
    chk("rlast_rd", rd_ostdg, 1);
    // ID 25 hits masks 01 and 20: lowest index wins.
    o_bvalid = 1'b1;
    o_bch = 8'h25;
    i_bready = 4'b1110;
    #1;
    chk("b25_bvalid", i_bvalid, 4'b0001);
    chk("b25_bready", o_bready, 0);
    o_bch = 8'h02;
    #1;
    chk("unr_bvalid", i_bvalid, 0);
    chk("unr_bready", o_bready, 1);
    chk("unr_err0", err_unrouted, 0);
    cyc();
    o_bvalid = 1'b0;
    #1;
    chk("unr_err1", err_unrouted, 1);
    chk("unr_wr", wr_ostdg, 3);
    cyc();
    #1;
    chk("unr_sticky", err_unrouted, 1);
    // Asynchronous reset with traffic pending.
    i_awvalid = 4'hF;
    o_awready = 1'b1;
    i_wvalid = 4'hF;
    o_wready = 1'b1;
    i_arvalid = 4'hF;
    o_arready = 1'b1;
    o_bvalid = 1'b1;
    o_bch = 8'h01;
    i_bready = 4'hF;
    o_rvalid = 1'b1;
    o_rch = 8'h34;
    i_rready = 4'hF;
    areset = 1'b1;
    #1;
    chk("ar_awvalid", o_awvalid, 0);
    chk("ar_awready", i_awready, 0);
    chk("ar_wvalid", o_wvalid, 0);
    chk("ar_wready", i_wready, 0);
    chk("ar_arvalid", o_arvalid, 0);
    chk("ar_arready", i_arready, 0);
    chk("ar_bvalid", i_bvalid, 0);
    chk("ar_bready", o_bready, 0);
    chk("ar_rvalid", i_rvalid, 0);
    chk("ar_rready", o_rready, 0);
    chk("ar_wr", wr_ostdg, 0);
    chk("ar_rd", rd_ostdg, 0);
    chk("ar_err", err_unrouted, 0);
    cyc();
    idle();
    i_wvalid = 4'hF;
    o_wready = 1'b1;
    areset = 1'b0;
    #1;
    chk("post_wvalid", o_wvalid, 0);
    chk("post_wready", i_wready, 0);
    chk("post_wr", wr_ostdg, 0);
    chk("post_rd", rd_ostdg, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
